// File: rtl/bc_pingpong_ctrl.sv
// Sequencer for the two-bank ping-pong broadcast buffer between the VLSU load path and lane0.
// One bank is filled from full load-unit rows while the other is replayed element by element.
module bc_pingpong_ctrl #(
    parameter int NrLanes    = 4,
    parameter int MaxBlen    = 32,
    parameter int MaxReplays = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [$clog2(MaxBlen+1)-1:0]    cfg_rows_i,
    input  logic [$clog2(MaxReplays+1)-1:0] cfg_passes_i,
    input  logic [NrLanes-1:0]              ldu_req_i,
    output logic [NrLanes-1:0]              ldu_gnt_o,
    output logic [1:0]                      buf_push_o,
    input  logic [1:0]                      buf_full_i,
    output logic [1:0]                      buf_pop_o,
    output logic [1:0]                      buf_rewind_o,
    output logic [1:0]                      buf_flush_o,
    output logic                            rd_sel_o,
    output logic                            bc_valid_o,
    input  logic                            bc_ready_i,
    input  logic                            bc_invalidate_i,
    output logic                            block_done_o,
    output logic                            busy_o
);
    localparam int RowW  = $clog2(MaxBlen + 1);
    localparam int PassW = $clog2(MaxReplays + 1);
    localparam int ElemW = $clog2(MaxBlen * 2 * NrLanes + 1);

    typedef enum logic [1:0] {
        BANK_EMPTY  = 2'd0,
        BANK_FILL   = 2'd1,
        BANK_LOADED = 2'd2,
        BANK_DRAIN  = 2'd3
    } bank_state_e;

    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic             wr_id_q, wr_id_d;
    logic             rd_id_q, rd_id_d;
    logic [RowW-1:0]  rows_q, rows_d;
    logic [RowW-1:0]  wrow_q, wrow_d;
    logic [PassW-1:0] passes_q, passes_d;
    logic [PassW-1:0] pass_q, pass_d;
    logic [ElemW-1:0] elem_q, elem_d;

    logic [ElemW-1:0] elems_m1_s;
    logic [RowW-1:0]  cfg_rows_s;
    logic [PassW-1:0] cfg_passes_s;
    logic             last_elem_s;
    logic             last_pass_s;
    logic             wr_open_s;
    logic             grant_s;
    logic             rd_valid_s;

    assign cfg_ready_o = (bank_q[0] == BANK_EMPTY) && (bank_q[1] == BANK_EMPTY);
    assign busy_o      = ~cfg_ready_o;
    assign rd_sel_o    = rd_id_q;
    assign bc_valid_o  = rd_valid_s;

    assign elems_m1_s  = ElemW'(rows_q) * ElemW'(2 * NrLanes) - ElemW'(1);
    assign last_elem_s = (elem_q == elems_m1_s);
    assign last_pass_s = (pass_q == (passes_q - PassW'(1)));
    assign wr_open_s   = (bank_q[wr_id_q] == BANK_EMPTY) || (bank_q[wr_id_q] == BANK_FILL);
    assign grant_s     = (&ldu_req_i) && wr_open_s && !buf_full_i[wr_id_q];
    assign rd_valid_s  = (bank_q[rd_id_q] == BANK_LOADED) || (bank_q[rd_id_q] == BANK_DRAIN);

    // Clamp an out-of-range configuration into the legal window so counters always terminate.
    always_comb begin
        if (cfg_rows_i == '0) begin
            cfg_rows_s = RowW'(1);
        end else if (cfg_rows_i > RowW'(MaxBlen)) begin
            cfg_rows_s = RowW'(MaxBlen);
        end else begin
            cfg_rows_s = cfg_rows_i;
        end
        if (cfg_passes_i == '0) begin
            cfg_passes_s = PassW'(1);
        end else if (cfg_passes_i > PassW'(MaxReplays)) begin
            cfg_passes_s = PassW'(MaxReplays);
        end else begin
            cfg_passes_s = cfg_passes_i;
        end
    end

    // Next-state and strobe logic for configuration, write side and read side.
    always_comb begin
        bank_d[0]    = bank_q[0];
        bank_d[1]    = bank_q[1];
        wr_id_d      = wr_id_q;
        rd_id_d      = rd_id_q;
        rows_d       = rows_q;
        passes_d     = passes_q;
        wrow_d       = wrow_q;
        pass_d       = pass_q;
        elem_d       = elem_q;
        ldu_gnt_o    = '0;
        buf_push_o   = 2'b00;
        buf_pop_o    = 2'b00;
        buf_rewind_o = 2'b00;
        buf_flush_o  = 2'b00;
        block_done_o = 1'b0;

        if (cfg_valid_i && cfg_ready_o) begin
            rows_d   = cfg_rows_s;
            passes_d = cfg_passes_s;
        end else begin
            rows_d   = rows_q;
            passes_d = passes_q;
        end

        // Invalidate wins over a coincident pop; the aborted block never signals done.
        if (rd_valid_s && bc_invalidate_i) begin
            buf_flush_o[rd_id_q] = 1'b1;
            bank_d[rd_id_q]      = BANK_EMPTY;
            rd_id_d              = ~rd_id_q;
            elem_d               = '0;
            pass_d               = '0;
        end else if (rd_valid_s && bc_ready_i) begin
            buf_pop_o[rd_id_q] = 1'b1;
            bank_d[rd_id_q]    = BANK_DRAIN;
            if (last_elem_s && !last_pass_s) begin
                buf_rewind_o[rd_id_q] = 1'b1;
                pass_d                = pass_q + PassW'(1);
                elem_d                = '0;
            end else if (last_elem_s) begin
                buf_flush_o[rd_id_q] = 1'b1;
                block_done_o         = 1'b1;
                bank_d[rd_id_q]      = BANK_EMPTY;
                rd_id_d              = ~rd_id_q;
                elem_d               = '0;
                pass_d               = '0;
            end else begin
                elem_d = elem_q + ElemW'(1);
            end
        end else begin
            elem_d = elem_q;
        end

        // The write bank is always EMPTY/FILL here, so it never collides with the read update.
        if (grant_s) begin
            ldu_gnt_o           = '1;
            buf_push_o[wr_id_q] = 1'b1;
            if (wrow_q == (rows_q - RowW'(1))) begin
                bank_d[wr_id_q] = BANK_LOADED;
                wrow_d          = '0;
                wr_id_d         = ~wr_id_q;
            end else begin
                bank_d[wr_id_q] = BANK_FILL;
                wrow_d          = wrow_q + RowW'(1);
            end
        end else begin
            wrow_d = wrow_q;
        end
    end

    // State register; banks reset themselves, so no flush is issued here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_id_q   <= 1'b0;
            rd_id_q   <= 1'b0;
            rows_q    <= RowW'(1);
            passes_q  <= PassW'(1);
            wrow_q    <= '0;
            pass_q    <= '0;
            elem_q    <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_id_q   <= wr_id_d;
            rd_id_q   <= rd_id_d;
            rows_q    <= rows_d;
            passes_q  <= passes_d;
            wrow_q    <= wrow_d;
            pass_q    <= pass_d;
            elem_q    <= elem_d;
        end
    end

endmodule

// File: tb/tb_bc_pingpong_ctrl.sv
// Randomized scoreboard bench for bc_pingpong_ctrl: a block-level model predicts grants,
// presentation and read-side strobes; a monitor compares them as the DUT shows them.
module tb_bc_pingpong_ctrl;
    localparam int NL = 4;
    localparam int MB = 32;
    localparam int MR = 16;
    localparam int RW = $clog2(MB + 1);
    localparam int PW = $clog2(MR + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [RW-1:0] cfg_rows_i = '0;
    logic [PW-1:0] cfg_passes_i = '0;
    logic [NL-1:0] ldu_req_i = '0;
    logic [NL-1:0] ldu_gnt_o;
    logic [1:0]    buf_push_o;
    logic [1:0]    buf_full_i = 2'b00;
    logic [1:0]    buf_pop_o;
    logic [1:0]    buf_rewind_o;
    logic [1:0]    buf_flush_o;
    logic          rd_sel_o;
    logic          bc_valid_o;
    logic          bc_ready_i = 1'b0;
    logic          bc_invalidate_i = 1'b0;
    logic          block_done_o;
    logic          busy_o;

    bc_pingpong_ctrl #(.NrLanes(NL), .MaxBlen(MB), .MaxReplays(MR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_rows_i(cfg_rows_i), .cfg_passes_i(cfg_passes_i),
        .ldu_req_i(ldu_req_i), .ldu_gnt_o(ldu_gnt_o),
        .buf_push_o(buf_push_o), .buf_full_i(buf_full_i),
        .buf_pop_o(buf_pop_o), .buf_rewind_o(buf_rewind_o), .buf_flush_o(buf_flush_o),
        .rd_sel_o(rd_sel_o), .bc_valid_o(bc_valid_o), .bc_ready_i(bc_ready_i),
        .bc_invalidate_i(bc_invalidate_i), .block_done_o(block_done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [NL-1:0] gnt; logic [1:0] push; logic valid; logic sel; logic cfg_rdy; } cyc_t;
    typedef struct { int cyc; logic [1:0] pop; logic [1:0] rew; logic [1:0] fl; logic done; } ev_t;
    typedef struct { int bank; int rows; int passes; int inv_at; } blk_t;

    cyc_t cyc_q[$];
    ev_t  ev_q[$];
    blk_t rdq[$];
    cyc_t exp_c;
    ev_t  exp_e;

    int total = 0;
    int bad = 0;
    int cyc_n = 0;
    bit mon_en = 1'b0;
    bit directed = 1'b0;

    // Block-level model: config, write bank, rows written, completed blocks awaiting read.
    int m_rows = 1;
    int m_passes = 1;
    int m_wr_bank = 0;
    int m_rd_bank = 0;
    int m_wrows = 0;
    int m_pops = 0;
    int to_write = 0;
    bit m_done [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(bc_valid_o), 32'd0);
        chk({tag, "_rd_sel"}, 32'(rd_sel_o), 32'd0);
        chk({tag, "_gnt_push"}, 32'({ldu_gnt_o, buf_push_o}), 32'd0);
        chk({tag, "_rd_strobes"}, 32'({buf_pop_o, buf_rewind_o, buf_flush_o, block_done_o}), 32'd0);
    endtask

    task automatic cycle_step(input bit want_cfg, input int nr, input int np);
        bit            idle, readable, inv, gnt_e, retire;
        logic [NL-1:0] req;
        logic [1:0]    full;
        logic          rdy;
        cyc_t          c;
        ev_t           e;
        blk_t          b, nb;
        int            elems;
        @(posedge clk_i);
        #1;
        cyc_n++;
        idle     = !m_done[0] && !m_done[1] && (m_wrows == 0);
        readable = (rdq.size() != 0);

        cfg_valid_i  = 1'b0;
        cfg_rows_i   = RW'($urandom);
        cfg_passes_i = PW'($urandom);
        if (want_cfg) begin
            cfg_valid_i  = 1'b1;
            cfg_rows_i   = RW'(nr);
            cfg_passes_i = PW'(np);
        end else if (!idle && $urandom_range(0, 15) == 0) begin
            cfg_valid_i = 1'b1;
        end
        req = '0;
        if (to_write > 0 && !want_cfg) begin
            if (directed) req = '1;
            else begin
                case ($urandom_range(0, 9))
                    0, 1:    req = NL'($urandom_range(0, 2**NL - 2));
                    2:       req = '0;
                    default: req = '1;
                endcase
            end
        end
        full = 2'b00;
        if (!directed && $urandom_range(0, 7) == 0) full = 2'($urandom_range(1, 3));
        rdy = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
        inv = 1'b0;
        if (readable && rdq[0].inv_at == m_pops) begin
            inv = 1'b1;
            rdy = 1'b1;
        end else if (!readable && !directed && $urandom_range(0, 9) == 0) begin
            inv = 1'b1;
        end
        ldu_req_i       = req;
        buf_full_i      = full;
        bc_ready_i      = rdy;
        bc_invalidate_i = inv;

        gnt_e     = (req == '1) && !m_done[m_wr_bank] && !full[m_wr_bank];
        c.gnt     = gnt_e ? '1 : '0;
        c.push    = gnt_e ? 2'(1 << m_wr_bank) : 2'b00;
        c.valid   = readable;
        c.sel     = 1'(m_rd_bank);
        c.cfg_rdy = idle;
        cyc_q.push_back(c);
        mon_en = 1'b1;

        e = '{cyc: cyc_n, pop: 2'b00, rew: 2'b00, fl: 2'b00, done: 1'b0};
        retire = 1'b0;
        b = '{bank: 0, rows: 1, passes: 1, inv_at: -1};
        if (readable) begin
            b = rdq[0];
            elems = b.rows * 2 * NL;
            if (inv) begin
                e.fl = 2'(1 << b.bank);
                retire = 1'b1;
            end else if (rdy) begin
                e.pop = 2'(1 << b.bank);
                m_pops++;
                if (m_pops == elems * b.passes) begin
                    e.fl = 2'(1 << b.bank);
                    e.done = 1'b1;
                    retire = 1'b1;
                end else if (m_pops % elems == 0) begin
                    e.rew = 2'(1 << b.bank);
                end
            end
        end
        if (e.pop != 2'b00 || e.fl != 2'b00) ev_q.push_back(e);

        if (retire) begin
            m_done[b.bank] = 1'b0;
            void'(rdq.pop_front());
            m_pops = 0;
            m_rd_bank ^= 1;
        end
        if (gnt_e) begin
            m_wrows++;
            if (m_wrows == m_rows) begin
                nb.bank   = m_wr_bank;
                nb.rows   = m_rows;
                nb.passes = m_passes;
                nb.inv_at = (!directed && $urandom_range(0, 3) == 0) ?
                            int'($urandom_range(0, m_rows * 2 * NL * m_passes - 1)) : -1;
                rdq.push_back(nb);
                m_done[m_wr_bank] = 1'b1;
                m_wr_bank ^= 1;
                m_wrows = 0;
                to_write--;
            end
        end
        if (cfg_valid_i && idle) begin
            m_rows   = nr;
            m_passes = np;
        end
    endtask

    task automatic run_episode(input bit do_cfg, input int nr, input int np, input int nblk,
                               input bit dir, input int stop_pops);
        int guard;
        directed = dir;
        if (do_cfg) cycle_step(1'b1, nr, np);
        to_write = nblk;
        guard = 0;
        while ((to_write > 0 || rdq.size() != 0) && guard < 20000 &&
               !(stop_pops > 0 && m_pops >= stop_pops)) begin
            cycle_step(1'b0, 0, 0);
            guard++;
        end
        if (guard >= 20000) chk("episode_timeout", 32'(guard), 32'd0);
    endtask

    // Monitor: per-cycle expectations every cycle, read-side events whenever the DUT shows one.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (cyc_q.size() == 0) begin
                chk("cyc_queue_underflow", 32'(cyc_q.size()), 32'd1);
            end else begin
                exp_c = cyc_q.pop_front();
                chk("gnt", 32'(ldu_gnt_o), 32'(exp_c.gnt));
                chk("push", 32'(buf_push_o), 32'(exp_c.push));
                chk("valid", 32'(bc_valid_o), 32'(exp_c.valid));
                chk("rd_sel", 32'(rd_sel_o), 32'(exp_c.sel));
                chk("cfg_ready", 32'(cfg_ready_o), 32'(exp_c.cfg_rdy));
                chk("busy", 32'(busy_o), 32'(!exp_c.cfg_rdy));
            end
            if ((|buf_pop_o) || (|buf_rewind_o) || (|buf_flush_o) || block_done_o) begin
                if (ev_q.size() == 0) begin
                    chk("unexpected_event", 32'({buf_pop_o, buf_rewind_o, buf_flush_o, block_done_o}), 32'd0);
                end else begin
                    exp_e = ev_q.pop_front();
                    chk("ev_cycle", 32'(cyc_n), 32'(exp_e.cyc));
                    chk("pop", 32'(buf_pop_o), 32'(exp_e.pop));
                    chk("rewind", 32'(buf_rewind_o), 32'(exp_e.rew));
                    chk("flush", 32'(buf_flush_o), 32'(exp_e.fl));
                    chk("block_done", 32'(block_done_o), 32'(exp_e.done));
                end
            end else if (ev_q.size() != 0 && ev_q[0].cyc <= cyc_n) begin
                chk("missing_event", 32'({buf_pop_o, buf_rewind_o, buf_flush_o, block_done_o}),
                    32'({ev_q[0].pop, ev_q[0].rew, ev_q[0].fl, ev_q[0].done}));
                void'(ev_q.pop_front());
            end
        end
    end

    initial begin
        m_done[0] = 1'b0;
        m_done[1] = 1'b0;
        #1 rst_ni = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        run_episode(1'b1, 2, 1, 1, 1'b1, 0);
        run_episode(1'b1, 1, 3, 1, 1'b1, 0);
        run_episode(1'b1, 2, 1, 3, 1'b1, 0);
        run_episode(1'b1, 32, 1, 2, 1'b0, 0);
        run_episode(1'b1, 1, 16, 2, 1'b0, 0);
        for (int ep = 0; ep < 12; ep++) begin
            run_episode(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                        int'($urandom_range(1, 3)), 1'b0, 0);
        end

        // Asynchronous reset in the middle of a drain.
        run_episode(1'b1, 4, 2, 2, 1'b1, 5);
        @(negedge clk_i);
        #1 mon_en = 1'b0;
        ldu_req_i = '0;
        cfg_valid_i = 1'b0;
        buf_full_i = 2'b00;
        bc_invalidate_i = 1'b0;
        bc_ready_i = 1'b1;
        chk("pre_reset_valid", 32'(bc_valid_o), 32'(rdq.size() != 0));
        chk("ev_leftover_mid", 32'(ev_q.size()), 32'd0);
        rst_ni = 1'b0;
        #1 chk_reset_outputs("async_reset");
        cyc_q.delete();
        ev_q.delete();
        rdq.delete();
        m_rows = 1; m_passes = 1; m_wr_bank = 0; m_rd_bank = 0;
        m_wrows = 0; m_pops = 0; to_write = 0;
        m_done[0] = 1'b0;
        m_done[1] = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // No new configuration: the block must use the reset values rows=1, passes=1.
        run_episode(1'b0, 0, 0, 1, 1'b1, 0);
        run_episode(1'b1, 3, 2, 2, 1'b0, 0);
        @(negedge clk_i);
        #1 mon_en = 1'b0;
        chk("ev_leftover_end", 32'(ev_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
